syscall_unit: RTL and testbench

Parametrised, synthesizable syscall service unit for the MIPS core. It sits beside the execute stage and decodes the syscall code in `v0`, stalling the pipeline until each request is serviced. Print requests are queued into an output FIFO for a host or console consumer. It also keeps saturating cycle and retired-instruction counters, and drains the FIFO before halting on exit.

---
 rtl/syscall_unit.sv | 251 +++++++++++++++++++++++++
 tb/tb_syscall_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syscall_unit.sv
// syscall_unit: syscall service unit that sits beside the MIPS execute stage.
//
// Decodes the syscall code on v0 while syscall_valid is high and stalls the
// pipeline until the request is serviced. Print requests (int / char) are
// queued into a first-word fall-through FIFO for a host or console consumer.
// Exit requests latch an exit status, wait for the FIFO to drain and then halt
// permanently until reset. Saturating cycle and retired-instruction counters
// run while the unit is not halted.
//
// Optional build macro: SYSCALL_TRACE_EN (simulation only). When defined, each
// push is echoed with $display and entering HALTED prints a run summary and
// calls $finish. Port behaviour is identical with or without the macro.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   syscall_valid     syscall in execute; held until syscall_ack
//   v0, a0            syscall code and argument
//   inst_retire       one instruction retires this cycle
//   stall             pipeline hold request
//   syscall_ack       one-cycle pulse, request serviced (never for exits)
//   out_valid/ready   FIFO head handshake
//   out_kind/data     FIFO head: kind 0 = integer, 1 = character
//   halted            program has exited
//   exit_code         latched exit status
//   err_unknown       sticky unsupported-code flag
//   cycle_count       non-halted cycles since reset (saturating)
//   inst_count        retired instructions since reset (saturating)

module syscall_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CNT_W      = 48,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              syscall_valid,
  input  logic [DATA_W-1:0] v0,
  input  logic [DATA_W-1:0] a0,
  input  logic              inst_retire,
  output logic              stall,
  output logic              syscall_ack,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_kind,
  output logic [DATA_W-1:0] out_data,
  output logic              halted,
  output logic [DATA_W-1:0] exit_code,
  output logic              err_unknown,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  inst_count
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FullCount = (AW + 1)'(FIFO_DEPTH);

  localparam logic [DATA_W-1:0] CodePrintInt  = DATA_W'(1);
  localparam logic [DATA_W-1:0] CodeExit      = DATA_W'(10);
  localparam logic [DATA_W-1:0] CodePrintChar = DATA_W'(11);
  localparam logic [DATA_W-1:0] CodeExit2     = DATA_W'(17);

  localparam logic [1:0] KindInt  = 2'd0;
  localparam logic [1:0] KindChar = 2'd1;

  typedef enum logic [1:0] {
    StIdle,
    StAck,
    StDrain,
    StHalted
  } state_e;

  state_e state;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic              is_print_int;
  logic              is_print_char;
  logic              is_print;
  logic              is_exit;
  logic [1:0]        push_kind;
  logic [DATA_W-1:0] push_data;

  always_comb begin
    is_print_int  = (v0 == CodePrintInt);
    is_print_char = (v0 == CodePrintChar);
    is_print      = is_print_int || is_print_char;
    is_exit       = (v0 == CodeExit) || (v0 == CodeExit2);
    push_kind     = is_print_char ? KindChar : KindInt;
    push_data     = is_print_char ? DATA_W'(a0[7:0]) : a0;
  end

  // ---------------------------------------------------------------------------
  // Print FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic [1:0]        mem_kind [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;

  always_comb begin
    fifo_empty = (count == '0);
    // Full comes straight from the occupancy register, so a push while full is
    // refused even if the head pops in the same cycle; the request retries.
    fifo_full  = (count == FullCount);
    push       = (state == StIdle) && syscall_valid && is_print && !fifo_full;
    pop        = !fifo_empty && out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= push_data;
      mem_kind[wr_ptr] <= push_kind;
    end
  end

  always_comb begin
    out_valid = !fifo_empty;
    out_kind  = fifo_empty ? 2'd0 : mem_kind[rd_ptr];
    out_data  = fifo_empty ? '0 : mem_data[rd_ptr];
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      syscall_ack <= 1'b0;
      halted      <= 1'b0;
      exit_code   <= '0;
      err_unknown <= 1'b0;
    end else begin
      syscall_ack <= 1'b0;
      unique case (state)
        StIdle: begin
          if (syscall_valid) begin
            if (is_exit) begin
              exit_code <= (v0 == CodeExit2) ? a0 : '0;
              state     <= StDrain;
            end else if (is_print) begin
              // A full FIFO keeps the request waiting here with stall high.
              if (!fifo_full) begin
                state       <= StAck;
                syscall_ack <= 1'b1;
              end
            end else begin
              err_unknown <= 1'b1;
              state       <= StAck;
              syscall_ack <= 1'b1;
            end
          end
        end
        // syscall_valid is still high here; ignoring it avoids double service.
        StAck: begin
          state <= StIdle;
        end
        StDrain: begin
          if (fifo_empty) begin
            state  <= StHalted;
            halted <= 1'b1;
          end
        end
        StHalted: begin
          state <= StHalted;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    stall = (syscall_valid && (state == StIdle)) || (state == StDrain) ||
            (state == StHalted);
  end

  // ---------------------------------------------------------------------------
  // Performance counters (saturating, frozen once halted)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count <= '0;
      inst_count  <= '0;
    end else if (state != StHalted) begin
      if (cycle_count != '1) begin
        cycle_count <= cycle_count + CNT_W'(1);
      end
      if (inst_retire && (inst_count != '1)) begin
        inst_count <= inst_count + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Simulation trace
  // ---------------------------------------------------------------------------
`ifdef SYSCALL_TRACE_EN
  logic trace_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      trace_done <= 1'b0;
    end else begin
      if (push) begin
        if (push_kind == KindChar) begin
          $display("%c", a0[7:0]);
        end else begin
          $display("a0 = %0d", $signed(a0));
        end
      end
      if ((state == StHalted) && !trace_done) begin
        trace_done <= 1'b1;
        $display("exit_code = %0d, cycles = %0d, insts = %0d, insts/clock = %0d",
                 exit_code, cycle_count, inst_count,
                 (cycle_count == '0) ? '0 : (inst_count / cycle_count));
        $finish;
      end
    end
  end
`else
  // Synthesizable build: no trace logic.
`endif

endmodule

// File: tb/tb_syscall_unit.sv
// Self-checking bench for syscall_unit: directed scenarios followed by random
// traffic, all compared every cycle against a queue-based reference model.

module tb_syscall_unit;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 48;
  localparam int unsigned DEPTH  = 8;
  localparam longint unsigned CntMax = (64'd1 << CNT_W) - 64'd1;

  logic              clk = 1'b0;
  logic              rst;
  logic              syscall_valid;
  logic [DATA_W-1:0] v0;
  logic [DATA_W-1:0] a0;
  logic              inst_retire;
  logic              stall;
  logic              syscall_ack;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_kind;
  logic [DATA_W-1:0] out_data;
  logic              halted;
  logic [DATA_W-1:0] exit_code;
  logic              err_unknown;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  inst_count;

  syscall_unit #(
    .DATA_W     (DATA_W),
    .CNT_W      (CNT_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .syscall_valid (syscall_valid),
    .v0            (v0),
    .a0            (a0),
    .inst_retire   (inst_retire),
    .stall         (stall),
    .syscall_ack   (syscall_ack),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_kind      (out_kind),
    .out_data      (out_data),
    .halted        (halted),
    .exit_code     (exit_code),
    .err_unknown   (err_unknown),
    .cycle_count   (cycle_count),
    .inst_count    (inst_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: pending-entry queue plus a few behavioural flags.
  logic [DATA_W+1:0] q[$];
  bit                m_ack;     // request serviced last edge, ack visible now
  bit                m_drain;   // exit accepted, waiting for the queue to empty
  bit                m_halt;
  bit                m_err;
  logic [DATA_W-1:0] m_exit;
  longint unsigned   m_cyc;
  longint unsigned   m_inst;
  bit                exp_ack_now;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ack   = 0;
    m_drain = 0;
    m_halt  = 0;
    m_err   = 0;
    m_exit  = '0;
    m_cyc   = 0;
    m_inst  = 0;
  endtask

  task automatic check_outputs();
    bit                idle;
    logic [DATA_W+1:0] head;
    idle = !m_ack && !m_drain && !m_halt;
    head = (q.size() != 0) ? q[0] : '0;
    chk("stall", stall, (syscall_valid && idle) || m_drain || m_halt);
    chk("syscall_ack", syscall_ack, m_ack);
    chk("out_valid", out_valid, q.size() != 0);
    chk("out_kind", out_kind, head[DATA_W+1:DATA_W]);
    chk("out_data", out_data, head[DATA_W-1:0]);
    chk("halted", halted, m_halt);
    chk("exit_code", exit_code, m_exit);
    chk("err_unknown", err_unknown, m_err);
    chk("cycle_count", cycle_count, m_cyc);
    chk("inst_count", inst_count, m_inst);
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_step();
    bit                idle;
    bit                was_full;
    bit                do_pop;
    bit                do_push;
    bit                new_ack;
    bit                was_halt;
    logic [DATA_W+1:0] item;
    if (rst) begin
      model_reset();
      return;
    end
    idle     = !m_ack && !m_drain && !m_halt;
    was_full = (q.size() == DEPTH);
    do_pop   = (q.size() != 0) && out_ready;
    was_halt = m_halt;
    do_push  = 0;
    new_ack  = 0;
    item     = '0;
    if (m_drain && q.size() == 0) begin
      m_drain = 0;
      m_halt  = 1;
    end
    if (idle && syscall_valid) begin
      case (v0)
        32'd1: if (!was_full) begin
          do_push = 1;
          new_ack = 1;
          item    = {2'd0, a0};
        end
        32'd11: if (!was_full) begin
          do_push = 1;
          new_ack = 1;
          item    = {2'd1, 24'd0, a0[7:0]};
        end
        32'd10: begin
          m_exit  = '0;
          m_drain = 1;
        end
        32'd17: begin
          m_exit  = a0;
          m_drain = 1;
        end
        default: begin
          m_err   = 1;
          new_ack = 1;
        end
      endcase
    end
    m_ack = new_ack;
    if (!was_halt) begin
      if (m_cyc < CntMax) m_cyc++;
      if (inst_retire && m_inst < CntMax) m_inst++;
    end
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(item);
  endtask

  // One clock: compare at the falling edge, step model, return just after rise.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    exp_ack_now = m_ack;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [DATA_W-1:0] code, input logic [DATA_W-1:0] arg);
    syscall_valid = 1;
    v0            = code;
    a0            = arg;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (exp_ack_now) break;
    end
    syscall_valid = 0;
  endtask

  bit                req_active;
  int                r;
  longint unsigned   frozen_cyc;

  initial begin
    rst           = 1;
    syscall_valid = 0;
    v0            = '0;
    a0            = '0;
    inst_retire   = 0;
    out_ready     = 0;
    req_active    = 0;
    exp_ack_now   = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 0;

    // Reset state.
    cycle();

    // Print int 42: serviced after one stall cycle.
    syscall_valid = 1;
    v0            = 32'd1;
    a0            = 32'd42;
    cycle();
    #1;
    chk("p42_ack", syscall_ack, 1);
    chk("p42_valid", out_valid, 1);
    chk("p42_kind", out_kind, 0);
    chk("p42_data", out_data, 42);
    chk("p42_stall", stall, 0);
    cycle();
    syscall_valid = 0;
    out_ready     = 1;
    cycle();
    out_ready = 0;

    // Nine print-ints with the consumer stalled: the ninth waits for space.
    for (int i = 0; i < 8; i++) do_req(32'd1, 32'd100 + i);
    syscall_valid = 1;
    v0            = 32'd1;
    a0            = 32'd108;
    repeat (5) cycle();
    chk("full_stall", stall, 1);
    out_ready = 1;
    cycle();
    out_ready = 0;
    cycle();
    cycle();
    syscall_valid = 0;
    out_ready     = 1;
    repeat (9) cycle();
    chk("full_drained", out_valid, 0);
    out_ready = 0;

    // Print char keeps only the low byte.
    do_req(32'd11, 32'h1234_5641);
    #1;
    chk("char_kind", out_kind, 1);
    chk("char_data", out_data, 32'h41);
    out_ready = 1;
    cycle();
    out_ready = 0;

    // Unknown code: sticky error, no push, later prints still work.
    do_req(32'd5, 32'hdead_beef);
    #1;
    chk("unk_err", err_unknown, 1);
    chk("unk_nopush", out_valid, 0);
    do_req(32'd1, 32'd9);
    out_ready = 1;
    cycle();
    out_ready = 0;

    // Three queued entries then exit2(7) with the consumer ready.
    do_req(32'd1, 32'd1);
    do_req(32'd11, 32'h62);
    do_req(32'd1, 32'hffff_fffe);
    syscall_valid = 1;
    v0            = 32'd17;
    a0            = 32'd7;
    out_ready     = 1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (m_halt) break;
    end
    syscall_valid = 0;
    #1;
    chk("exit_halted", halted, 1);
    chk("exit_code7", exit_code, 7);
    frozen_cyc = m_cyc;
    syscall_valid = 1;
    v0            = 32'd1;
    repeat (5) cycle();
    syscall_valid = 0;
    chk("frozen_cyc", cycle_count, frozen_cyc);
    out_ready = 0;

    // Reset out of HALTED, then reset during DRAIN with entries pending.
    rst = 1;
    cycle();
    rst = 0;
    do_req(32'd1, 32'd11);
    do_req(32'd1, 32'd22);
    syscall_valid = 1;
    v0            = 32'd10;
    repeat (3) cycle();
    rst           = 1;
    syscall_valid = 0;
    cycle();
    rst = 0;
    #1;
    chk("rst_drain_valid", out_valid, 0);
    chk("rst_drain_halted", halted, 0);
    chk("rst_drain_stall", stall, 0);
    cycle();

    // 100 cycles with inst_retire on alternate cycles, then reset.
    rst = 1;
    cycle();
    rst = 0;
    for (int i = 0; i < 100; i++) begin
      inst_retire = (i % 2 == 0);
      cycle();
    end
    inst_retire = 0;
    chk("cnt_cyc100", cycle_count, 100);
    chk("cnt_inst50", inst_count, 50);
    rst = 1;
    cycle();
    rst = 0;
    #1;
    chk("cnt_cyc0", cycle_count, 0);
    chk("cnt_inst0", inst_count, 0);

    // Random traffic obeying the hold-until-ack protocol.
    for (int n = 0; n < 800; n++) begin
      out_ready   = (n < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      inst_retire = $urandom_range(0, 1);
      rst         = m_halt ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 149) == 0);
      if (rst) req_active = 0;
      if (!rst && !req_active && $urandom_range(0, 2) == 0) begin
        req_active = 1;
        r          = $urandom_range(0, 15);
        if (r < 6)       v0 = 32'd1;
        else if (r < 11) v0 = 32'd11;
        else if (r < 14) v0 = 32'($urandom_range(2, 9));
        else if (r == 14) v0 = 32'd10;
        else              v0 = 32'd17;
        a0 = $urandom;
      end
      syscall_valid = req_active;
      if (!req_active) begin
        v0 = $urandom;
        a0 = $urandom;
      end
      cycle();
      if (exp_ack_now) req_active = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
